// File: rtl/CorePack.sv
`default_nettype none
// ============================================================================
// Module      : CorePack (package)
// Description : Shared core type definitions. Provides the memory-operation
//               encoding used by the load/store path.
// Revision    : 1.0 - initial release
// ============================================================================
package CorePack;

    // Memory access size / signedness. Signed and unsigned variants of the
    // same size are identical for stores.
    typedef enum logic [2:0] {
        MEM_NO = 3'd0,
        MEM_B  = 3'd1,
        MEM_UB = 3'd2,
        MEM_H  = 3'd3,
        MEM_UH = 3'd4,
        MEM_W  = 3'd5,
        MEM_UW = 3'd6,
        MEM_D  = 3'd7
    } mem_op_enum;

endpackage
`default_nettype wire

// File: rtl/store_data_packer.sv
`default_nettype none
// ============================================================================
// Module      : store_data_packer
// Description : Registered valid/ready stage that turns a store request
//               (byte address, right-justified data, access size) into a
//               bus-aligned write beat: lane-positioned data, byte strobe and
//               bus-word-aligned address. Stores that straddle a bus-word
//               boundary are split into two beats when STORE_PACKER_SPLIT_EN
//               is defined; otherwise they produce a single error beat.
//
// Parameters  : DATA_WIDTH  bus / register width in bits (power of two, >=32)
//               ADDR_WIDTH  address width in bits
// Macro       : STORE_PACKER_SPLIT_EN  enables two-beat boundary-crossing stores
//
// Ports       : clk, rst          clock, synchronous active-high reset
//               req_valid/ready   store request handshake
//               req_addr          byte address of the store
//               req_data          raw store data, right-justified
//               req_mem_op        access size (CorePack::mem_op_enum)
//               out_valid/ready   write beat handshake
//               out_addr          beat address, low log2(DATA_BYTES) bits zero
//               out_wdata         lane-positioned write data
//               out_wmask         byte strobe, bit i enables byte i
//               out_err           error beat marker (wmask all-zero)
//               out_last          final beat of the current request
//
// Revision    : 1.0 - initial release
// ============================================================================
module store_data_packer #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [DATA_WIDTH-1:0]     req_data,
    input  CorePack::mem_op_enum      req_mem_op,

    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ADDR_WIDTH-1:0]     out_addr,
    output logic [DATA_WIDTH-1:0]     out_wdata,
    output logic [DATA_WIDTH/8-1:0]   out_wmask,
    output logic                      out_err,
    output logic                      out_last
);

    localparam int DATA_BYTES = DATA_WIDTH / 8;
    localparam int OFF_W      = $clog2(DATA_BYTES);
    localparam int SZ_W       = OFF_W + 1;   // holds 0..DATA_BYTES

    typedef enum logic [1:0] {
        S_EMPTY    = 2'd0,
        S_FULL     = 2'd1,
        S_SPLIT_HI = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_e                  state_q,     state_d;
    logic [ADDR_WIDTH-1:0]   out_addr_q,  out_addr_d;
    logic [DATA_WIDTH-1:0]   out_wdata_q, out_wdata_d;
    logic [DATA_BYTES-1:0]   out_wmask_q, out_wmask_d;
    logic                    out_err_q,   out_err_d;
    logic                    out_last_q,  out_last_d;
`ifdef STORE_PACKER_SPLIT_EN
    // Upper beat of a split store, parked until the lower beat is taken.
    logic [ADDR_WIDTH-1:0]   hi_addr_q,   hi_addr_d;
    logic [DATA_WIDTH-1:0]   hi_wdata_q,  hi_wdata_d;
    logic [DATA_BYTES-1:0]   hi_wmask_q,  hi_wmask_d;
`endif

    // ------------------------------------------------------------------
    // Request decode and lane positioning
    // ------------------------------------------------------------------
    logic [3:0]              w_bytes;
    logic [SZ_W-1:0]         w_size;
    logic [OFF_W-1:0]        w_off;
    logic [ADDR_WIDTH-1:0]   w_base;
    logic [DATA_BYTES-1:0]   w_m;
    logic [DATA_WIDTH-1:0]   w_bitmask;
    logic [DATA_WIDTH-1:0]   w_data_sz;
    logic                    w_cross;
    logic [DATA_WIDTH-1:0]   w_lo_wdata;
    logic [DATA_BYTES-1:0]   w_lo_wmask;
    logic [ADDR_WIDTH-1:0]   w_beat_addr;
    logic [DATA_WIDTH-1:0]   w_beat_wdata;
    logic [DATA_BYTES-1:0]   w_beat_wmask;
    logic                    w_beat_err;
    logic                    w_beat_last;
    logic                    w_accept;
    logic                    w_load;
`ifdef STORE_PACKER_SPLIT_EN
    logic [SZ_W-1:0]         w_hi_shift;
    logic [DATA_WIDTH-1:0]   w_hi_wdata;
    logic [DATA_BYTES-1:0]   w_hi_wmask;
`endif

    always_comb begin
        w_bytes = 4'd0;
        case (req_mem_op)
            CorePack::MEM_B,  CorePack::MEM_UB: w_bytes = 4'd1;
            CorePack::MEM_H,  CorePack::MEM_UH: w_bytes = 4'd2;
            CorePack::MEM_W,  CorePack::MEM_UW: w_bytes = 4'd4;
            CorePack::MEM_D:                    w_bytes = 4'd8;
            default:                            w_bytes = 4'd0;
        endcase
    end

    // Accesses wider than the bus are clamped to a full beat.
    assign w_size = (int'(w_bytes) > DATA_BYTES) ? SZ_W'(DATA_BYTES) : SZ_W'(w_bytes);
    assign w_off  = req_addr[OFF_W-1:0];
    assign w_base = {req_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};

    // A shift by the full width yields zero, so size==DATA_BYTES gives all ones.
    assign w_m = ~({DATA_BYTES{1'b1}} << w_size);

    always_comb begin
        w_bitmask = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            w_bitmask[8*i +: 8] = {8{w_m[i]}};
        end
    end

    assign w_data_sz  = req_data & w_bitmask;
    assign w_cross    = ({2'b00, w_off} + {1'b0, w_size}) > (SZ_W+1)'(DATA_BYTES);
    // Shifting left truncates anything past the top lane; for a crossing
    // store that is exactly the low-beat content.
    assign w_lo_wdata = w_data_sz << {w_off, 3'b000};
    assign w_lo_wmask = w_m << w_off;

`ifdef STORE_PACKER_SPLIT_EN
    assign w_hi_shift = SZ_W'(DATA_BYTES) - {1'b0, w_off};
    assign w_hi_wdata = w_data_sz >> {w_hi_shift, 3'b000};
    assign w_hi_wmask = w_m >> w_hi_shift;
`endif

    // Beat to be loaded when a request is accepted.
    always_comb begin
        w_beat_addr  = w_base;
        w_beat_wdata = w_lo_wdata;
        w_beat_wmask = w_lo_wmask;
        w_beat_err   = 1'b0;
        w_beat_last  = 1'b1;
        if (w_cross) begin
`ifdef STORE_PACKER_SPLIT_EN
            w_beat_last  = 1'b0;
`else
            w_beat_wdata = '0;
            w_beat_wmask = '0;
            w_beat_err   = 1'b1;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    // In FULL, out_last_q==0 means the low half of a split is on the bus and
    // the high half still has to go, so no new request may enter.
    always_comb begin
        req_ready = 1'b0;
        case (state_q)
            S_EMPTY:    req_ready = 1'b1;
            S_FULL:     req_ready = out_ready & out_last_q;
            default:    req_ready = 1'b0;
        endcase
    end

    assign w_accept = req_valid & req_ready;
    assign w_load   = w_accept & (req_mem_op != CorePack::MEM_NO);

    // ------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        out_addr_d  = out_addr_q;
        out_wdata_d = out_wdata_q;
        out_wmask_d = out_wmask_q;
        out_err_d   = out_err_q;
        out_last_d  = out_last_q;
`ifdef STORE_PACKER_SPLIT_EN
        hi_addr_d   = hi_addr_q;
        hi_wdata_d  = hi_wdata_q;
        hi_wmask_d  = hi_wmask_q;
        if (w_load) begin
            hi_addr_d  = w_base + ADDR_WIDTH'(DATA_BYTES);
            hi_wdata_d = w_hi_wdata;
            hi_wmask_d = w_hi_wmask;
        end
`endif

        case (state_q)
            S_EMPTY: begin
                if (w_load) begin
                    state_d = S_FULL;
                end
            end
            S_FULL: begin
                if (out_ready) begin
`ifdef STORE_PACKER_SPLIT_EN
                    if (!out_last_q) begin
                        state_d = S_SPLIT_HI;
                    end else
`endif
                    if (w_load) begin
                        state_d = S_FULL;
                    end else begin
                        state_d = S_EMPTY;
                    end
                end
            end
            S_SPLIT_HI: begin
                if (out_ready) begin
                    state_d = S_EMPTY;
                end
            end
            default: state_d = S_EMPTY;
        endcase

        if (w_load) begin
            out_addr_d  = w_beat_addr;
            out_wdata_d = w_beat_wdata;
            out_wmask_d = w_beat_wmask;
            out_err_d   = w_beat_err;
            out_last_d  = w_beat_last;
        end
`ifdef STORE_PACKER_SPLIT_EN
        else if (state_q == S_FULL && out_ready && !out_last_q) begin
            out_addr_d  = hi_addr_q;
            out_wdata_d = hi_wdata_q;
            out_wmask_d = hi_wmask_q;
            out_err_d   = 1'b0;
            out_last_d  = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_EMPTY;
            out_addr_q  <= '0;
            out_wdata_q <= '0;
            out_wmask_q <= '0;
            out_err_q   <= 1'b0;
            out_last_q  <= 1'b0;
`ifdef STORE_PACKER_SPLIT_EN
            hi_addr_q   <= '0;
            hi_wdata_q  <= '0;
            hi_wmask_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            out_addr_q  <= out_addr_d;
            out_wdata_q <= out_wdata_d;
            out_wmask_q <= out_wmask_d;
            out_err_q   <= out_err_d;
            out_last_q  <= out_last_d;
`ifdef STORE_PACKER_SPLIT_EN
            hi_addr_q   <= hi_addr_d;
            hi_wdata_q  <= hi_wdata_d;
            hi_wmask_q  <= hi_wmask_d;
`endif
        end
    end

    assign out_valid = (state_q != S_EMPTY);
    assign out_addr  = out_addr_q;
    assign out_wdata = out_wdata_q;
    assign out_wmask = out_wmask_q;
    assign out_err   = out_err_q;
    assign out_last  = out_last_q;

endmodule
`default_nettype wire

// File: tb/tb_store_data_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_data_packer
// Description : Directed self-checking bench for store_data_packer with a
//               64-bit bus. Expected beats are hand-computed constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_data_packer;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 req_valid;
    logic                 req_ready;
    logic [63:0]          req_addr;
    logic [63:0]          req_data;
    CorePack::mem_op_enum req_mem_op;
    logic                 out_valid;
    logic                 out_ready;
    logic [63:0]          out_addr;
    logic [63:0]          out_wdata;
    logic [7:0]           out_wmask;
    logic                 out_err;
    logic                 out_last;

    int checks = 0;
    int errors = 0;

    store_data_packer #(
        .DATA_WIDTH (64),
        .ADDR_WIDTH (64)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_mem_op (req_mem_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_wdata  (out_wdata),
        .out_wmask  (out_wmask),
        .out_err    (out_err),
        .out_last   (out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic [63:0] a, input logic [63:0] d,
                            input logic [7:0] m, input logic last, input logic err);
        chk({tag, ".valid"}, {63'd0, out_valid}, 64'd1);
        chk({tag, ".addr"},  out_addr, a);
        chk({tag, ".wdata"}, out_wdata, d);
        chk({tag, ".wmask"}, {56'd0, out_wmask}, {56'd0, m});
        chk({tag, ".last"},  {63'd0, out_last}, {63'd0, last});
        chk({tag, ".err"},   {63'd0, out_err}, {63'd0, err});
    endtask

    // Present a request; caller has already aligned to #1 after a clock edge.
    task automatic put(input logic [63:0] a, input logic [63:0] d, input CorePack::mem_op_enum op);
        req_valid  = 1'b1;
        req_addr   = a;
        req_data   = d;
        req_mem_op = op;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_data   = '0;
        req_mem_op = CorePack::MEM_NO;
        out_ready  = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst.valid", {63'd0, out_valid}, 64'd0);
        chk("rst.err",   {63'd0, out_err},   64'd0);
        chk("rst.last",  {63'd0, out_last},  64'd0);
        chk("rst.addr",  out_addr,  64'd0);
        chk("rst.wdata", out_wdata, 64'd0);
        chk("rst.wmask", {56'd0, out_wmask}, 64'd0);
        chk("rst.ready", {63'd0, req_ready}, 64'd1);

        // Word store
        put(64'h1004, 64'h1122334455667788, CorePack::MEM_W);
        step();
        req_valid = 1'b0;
        chk_beat("word", 64'h1000, 64'h5566778800000000, 8'hF0, 1'b1, 1'b0);
        step();
        chk("word.drain", {63'd0, out_valid}, 64'd0);

        // Byte store, upper bits of register ignored
        put(64'h2003, 64'hFFFF_FFFF_FFFF_FFAB, CorePack::MEM_UB);
        step();
        req_valid = 1'b0;
        chk_beat("byte", 64'h2000, 64'h00000000AB000000, 8'h08, 1'b1, 1'b0);
        step();

        // Misaligned half that still fits
        put(64'h4005, 64'hFFFF_0000_0000_BEEF, CorePack::MEM_H);
        step();
        req_valid = 1'b0;
        chk_beat("half", 64'h4000, 64'h00BEEF0000000000, 8'h60, 1'b1, 1'b0);
        step();

        // Crossing half
        put(64'h1007, 64'h7788, CorePack::MEM_H);
        step();
        req_valid = 1'b0;
`ifdef STORE_PACKER_SPLIT_EN
        chk_beat("xh.lo", 64'h1000, 64'h8800000000000000, 8'h80, 1'b0, 1'b0);
        chk("xh.lo.ready", {63'd0, req_ready}, 64'd0);
        step();
        chk_beat("xh.hi", 64'h1008, 64'h0000000000000077, 8'h01, 1'b1, 1'b0);
        chk("xh.hi.ready", {63'd0, req_ready}, 64'd0);
`else
        chk_beat("xh.err", 64'h1000, 64'h0, 8'h00, 1'b1, 1'b1);
`endif
        step();
        chk("xh.drain", {63'd0, out_valid}, 64'd0);

        // Crossing word
        put(64'h5006, 64'h0000_0000_AABB_CCDD, CorePack::MEM_UW);
        step();
        req_valid = 1'b0;
`ifdef STORE_PACKER_SPLIT_EN
        chk_beat("xw.lo", 64'h5000, 64'hCCDD000000000000, 8'hC0, 1'b0, 1'b0);
        step();
        chk_beat("xw.hi", 64'h5008, 64'h000000000000AABB, 8'h03, 1'b1, 1'b0);
`else
        chk_beat("xw.err", 64'h5000, 64'h0, 8'h00, 1'b1, 1'b1);
`endif
        step();

        // Back-pressure on a double store, then back-to-back beat
        out_ready = 1'b0;
        put(64'h3000, 64'h0123456789ABCDEF, CorePack::MEM_D);
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_beat("bp.hold", 64'h3000, 64'h0123456789ABCDEF, 8'hFF, 1'b1, 1'b0);
            chk("bp.ready", {63'd0, req_ready}, 64'd0);
            step();
        end
        out_ready = 1'b1;
        put(64'h300C, 64'h00000000DEADBEEF, CorePack::MEM_UW);
        #1;
        chk("b2b.ready", {63'd0, req_ready}, 64'd1);
        step();
        req_valid = 1'b0;
        chk_beat("b2b", 64'h3008, 64'hDEADBEEF00000000, 8'hF0, 1'b1, 1'b0);
        step();
        chk("b2b.drain", {63'd0, out_valid}, 64'd0);

        // MEM_NO is consumed without producing a beat
        put(64'h6000, 64'h1234, CorePack::MEM_NO);
        #1;
        chk("memno.ready", {63'd0, req_ready}, 64'd1);
        step();
        req_valid = 1'b0;
        chk("memno.valid", {63'd0, out_valid}, 64'd0);
        step();
        chk("memno.valid2", {63'd0, out_valid}, 64'd0);

        // Reset while a split (or error beat) is in flight
        put(64'h1007, 64'h7788, CorePack::MEM_H);
`ifndef STORE_PACKER_SPLIT_EN
        out_ready = 1'b0;
`endif
        step();
        req_valid = 1'b0;
`ifdef STORE_PACKER_SPLIT_EN
        step();
        chk_beat("rsthi.pre", 64'h1008, 64'h77, 8'h01, 1'b1, 1'b0);
        out_ready = 1'b0;
`else
        chk("rsterr.pre", {63'd0, out_err}, 64'd1);
`endif
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstmid.valid", {63'd0, out_valid}, 64'd0);
        chk("rstmid.wmask", {56'd0, out_wmask}, 64'd0);
        out_ready = 1'b1;
        step();
        chk("rstmid.nohi", {63'd0, out_valid}, 64'd0);
        step();
        chk("rstmid.nohi2", {63'd0, out_valid}, 64'd0);
        put(64'h2003, 64'hAB, CorePack::MEM_B);
        step();
        req_valid = 1'b0;
        chk_beat("post", 64'h2000, 64'h00000000AB000000, 8'h08, 1'b1, 1'b0);
        step();
        chk("post.drain", {63'd0, out_valid}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/store_data_packer.md
Name: store_data_packer

Overview:
- Parametrised successor to the core's combinational store-data replicator.
- Takes a store request (address, raw register data, mem_op), and produces a bus-aligned write beat: data shifted into byte lane position, a byte-strobe mask and a line-aligned address.
- Registered valid/ready stage between the MEM stage and the data-memory / D-cache write port.
- Handles accesses that straddle a bus-word boundary: either splits them into two beats or flags them as errors, selected by macro.

Parameters:
- DATA_WIDTH, 64, bus and register data width in bits; power of two, >= 32.
- ADDR_WIDTH, 64, address width in bits.
- DATA_BYTES, DATA_WIDTH/8, derived; bytes per bus beat; not overridable.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  store request valid.
- req_ready  out  1  packer can accept a request this cycle.
- req_addr  in  ADDR_WIDTH  byte address of store.
- req_data  in  DATA_WIDTH  raw store data, right-justified (rs2).
- req_mem_op  in  CorePack::mem_op_enum  access size (MEM_NO/B/UB/H/UH/W/UW/D).
- out_valid  out  1  write beat valid.
- out_ready  in  1  downstream accepts beat.
- out_addr  out  ADDR_WIDTH  beat address, low log2(DATA_BYTES) bits zero.
- out_wdata  out  DATA_WIDTH  lane-positioned write data.
- out_wmask  out  DATA_BYTES  byte strobe, bit i enables byte i.
- out_err  out  1  beat is an error marker; wmask is all-zero when set.
- out_last  out  1  final beat of the current request.

Behaviour:
- Reset: out_valid=0, out_err=0, out_last=0, out_addr=0, out_wdata=0, out_wmask=0, state=EMPTY. req_ready is combinational from state.
- Size: B/UB=1, H/UH=2, W/UW=4, D=8 bytes; signed and unsigned variants are identical. Sizes above DATA_BYTES are treated as DATA_BYTES.
- off = req_addr mod DATA_BYTES; base = req_addr with low bits cleared.
- data_sz = req_data masked to size*8 bits; m = (1<<size)-1.
- Fits (off+size <= DATA_BYTES):
  - single beat: out_addr=base, out_wdata=data_sz<<(8*off), out_wmask=m<<off, out_last=1, out_err=0.
  - Natural alignment is not required.
- Crosses (off+size > DATA_BYTES): handled per the optional feature.
- MEM_NO: request is consumed (req_ready as usual); no beat is produced; state is unchanged.
- States:
  - EMPTY: req_ready=1, out_valid=0.
  - FULL: out_valid=1; req_ready=out_ready, unless a split high beat is pending.
  - SPLIT_HI: out_valid=1, req_ready=0.
- Transitions:
  - EMPTY -> FULL on accept (req_valid & req_ready & mem_op!=MEM_NO).
  - FULL with out_ready:
    - -> SPLIT_HI if the low beat of a split was just sent;
    - else -> FULL if a new request is accepted the same cycle (back-to-back, no bubble);
    - else -> EMPTY.
  - SPLIT_HI with out_ready -> EMPTY.
- Latency: one cycle from request acceptance to out_valid. Throughput: one beat per cycle.
- Stability: while out_valid & !out_ready, all out_* are held stable.
- Unaccepted requests: req_* are ignored when req_ready=0.
- Mid-operation reset: rst in any state returns to EMPTY next edge. A pending high beat is discarded and no partial beat is issued afterwards.

Optional Feature:
- Macro: STORE_PACKER_SPLIT_EN.
- Defined: a crossing store issues two beats.
  - Low beat: out_addr=base, wdata=data_sz<<(8*off), wmask=(m<<off) truncated to DATA_BYTES, out_last=0.
  - High beat: out_addr=base+DATA_BYTES, wdata=data_sz>>(8*(DATA_BYTES-off)), wmask=m>>(DATA_BYTES-off), out_last=1.
  - req_ready=0 until the high beat is accepted. Address wraps modulo 2^ADDR_WIDTH.
- Undefined: a crossing store issues one beat with out_err=1, wmask=0, wdata=0, out_addr=base, out_last=1. SPLIT_HI is unreachable.

Test Plan:
- Word: addr 0x1004, data 0x1122334455667788, MEM_W, out_ready=1 -> next cycle out_addr 0x1000, wdata 0x5566778800000000, wmask 0xF0, last=1, err=0.
- Byte: addr 0x2003, data 0xFFFF_FFFF_FFFF_FFAB, MEM_UB -> out_addr 0x2000, wdata 0x00000000AB000000, wmask 0x08.
- Crossing half: addr 0x1007, data 0x7788, MEM_H.
  - With SPLIT_EN: beat0 addr 0x1000, wdata 0x8800000000000000, wmask 0x80, last=0; then beat1 addr 0x1008, wdata 0x77, wmask 0x01, last=1. req_ready=0 between the two beats.
  - Without SPLIT_EN: one beat, err=1, wmask 0x00.
- Back-pressure: hold out_ready=0 for 3 cycles with a D store at 0x3000 pending -> outputs stable, req_ready=0; out_ready=1 together with a new request -> back-to-back beats, no bubble.
- MEM_NO: req_valid=1 for one cycle -> req_ready=1, out_valid stays 0.
- Reset during SPLIT_HI: assert rst one cycle -> out_valid=0 next cycle, no high beat ever appears, next request behaves normally.
